// File: rtl/d_shift_register.sv
// WIDTH-bit register bank with load, shift, rotate and true/complement outputs.
// Counts shifts/rotates since the last load and pulses done when the count first reaches WIDTH.
module d_shift_register #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [2:0]                 mode,
  input  logic                       serial_in,
  input  logic [WIDTH-1:0]           data_input,
  output logic [WIDTH-1:0]           Q,
  output logic [WIDTH-1:0]           Q_hat,
  output logic                       serial_out,
  output logic [$clog2(WIDTH+1)-1:0] shift_cnt,
  output logic                       done
);

  localparam int CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_PRE = CW'(WIDTH - 1);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;

  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             is_shift;

  always_comb begin
    q_d      = q_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    is_shift = 1'b0;
    if (en) begin
      case (mode)
        MODE_LOAD: begin
          q_d   = data_input;
          cnt_d = '0;
        end
        MODE_SHL: begin
          q_d      = {q_q[WIDTH-2:0], serial_in};
          is_shift = 1'b1;
        end
        MODE_SHR: begin
          q_d      = {serial_in, q_q[WIDTH-1:1]};
          is_shift = 1'b1;
        end
        MODE_ROL: begin
          q_d      = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          is_shift = 1'b1;
        end
        MODE_ROR: begin
          q_d      = {q_q[0], q_q[WIDTH-1:1]};
          is_shift = 1'b1;
        end
        default: begin
          q_d = q_q;
        end
      endcase
      // Count saturates; done fires only on the WIDTH-1 -> WIDTH transition.
      if (is_shift && (cnt_q != CNT_MAX)) begin
        cnt_d  = cnt_q + 1'b1;
        done_d = (cnt_q == CNT_PRE);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q    <= RESET_VAL;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign Q          = q_q;
  assign Q_hat      = ~q_q;
  assign serial_out = ((mode == MODE_SHL) || (mode == MODE_ROL)) ? q_q[WIDTH-1] : q_q[0];
  assign shift_cnt  = cnt_q;
  assign done       = done_q;

  logic unused_hold;
  assign unused_hold = (MODE_HOLD == 3'b000);

endmodule
